// File: rtl/clock_pkg.sv
// Shared definitions for the BCD clock counters: digit width and the
// elaboration-time helpers used to build and validate packed BCD values.
package clock_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;
    localparam int MAX_W      = MAX_DIGITS * BCD_W;

    // Convert a non-negative integer into packed BCD, digit 0 in the low nibble.
    function automatic logic [MAX_W-1:0] to_bcd(input int value);
        logic [MAX_W-1:0] res;
        int               rem;
        res = '0;
        rem = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            res[i*BCD_W +: BCD_W] = BCD_W'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    // True when every nibble of the (zero-extended) vector is a decimal digit.
    function automatic logic is_bcd(input logic [MAX_W-1:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            ok = ok & (vec[i*BCD_W +: BCD_W] <= 4'd9);
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register. It either takes a forced value (set) or steps by
// one when its carry/borrow-in is high, wrapping 9->0 going up and 0->9
// going down; wrap_o tells the next digit to step as well.
module bcd_digit
    import clock_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_i,
    input  logic [BCD_W-1:0] set_val_i,
    input  logic             step_i,
    input  logic             up_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             wrap_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;
    logic             at_edge_s;

    // Digit sits at the value where a step in the current direction wraps.
    always_comb begin
        at_edge_s = up_i ? (digit_q == 4'd9) : (digit_q == 4'd0);
    end

    // Next digit value: forced value wins, otherwise one BCD step or hold.
    always_comb begin
        digit_d = digit_q;
        if (set_i) begin
            digit_d = set_val_i;
        end else if (step_i) begin
            if (at_edge_s) begin
                digit_d = up_i ? 4'd0 : 4'd9;
            end else begin
                digit_d = up_i ? (digit_q + 4'd1) : (digit_q - 4'd1);
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit storage with asynchronous reset to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign wrap_o  = step_i & at_edge_s;

endmodule

// File: rtl/bcd_counter_mod.sv
// Parametrised BCD modulo-N up/down counter with clear, validated load and
// single-cycle carry/borrow/load-error pulses. The per-digit stepping lives
// in bcd_digit; terminal-count detection and forced wraps are decided here.
module bcd_counter_mod
    import clock_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   dout,
    output logic                  cout,
    output logic                  bout,
    output logic                  load_err
);

    localparam int DW = BCD_W * DIGITS;

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_counter_mod: DIGITS must be in 1..4");
    end
    if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_modulus
        $error("bcd_counter_mod: MODULUS must be in 2..10**DIGITS");
    end

    // Highest legal count (MODULUS-1) as packed BCD.
    localparam logic [MAX_W-1:0] TERM_FULL = to_bcd(MODULUS - 1);
    localparam logic [DW-1:0]    TERM      = TERM_FULL[DW-1:0];

    logic [DW-1:0]   dout_s;
    logic            set_s;
    logic [DW-1:0]   set_val_s;
    logic            step_s;
    logic            legal_s;
    logic            load_ok_s;
    logic [DIGITS:0] chain_s;
    logic            unused_top_wrap_s;
    logic            cout_q, cout_d;
    logic            bout_q, bout_d;
    logic            load_err_q, load_err_d;

    // Packed BCD order matches numeric order, so "< MODULUS" is "<= TERM".
    always_comb begin
        legal_s   = is_bcd(MAX_W'(dout_s)) && (dout_s <= TERM);
        load_ok_s = is_bcd(MAX_W'(load_val)) && (load_val <= TERM);
    end

    // Decide this edge's action with priority clear > load > en.
    always_comb begin
        set_s      = 1'b0;
        set_val_s  = '0;
        step_s     = 1'b0;
        cout_d     = 1'b0;
        bout_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            set_s = 1'b1;
        end else if (load) begin
            if (load_ok_s) begin
                set_s     = 1'b1;
                set_val_s = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (!legal_s) begin
                // Corrupt state recovers to zero silently.
                set_s = 1'b1;
            end else if (dir && (dout_s == TERM)) begin
                set_s  = 1'b1;
                cout_d = 1'b1;
            end else if (!dir && (dout_s == '0)) begin
                set_s     = 1'b1;
                set_val_s = TERM;
                bout_d    = 1'b1;
            end else begin
                step_s = 1'b1;
            end
        end else begin
            step_s = 1'b0;
        end
    end

    assign chain_s[0] = step_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .set_i     (set_s),
            .set_val_i (set_val_s[g*BCD_W +: BCD_W]),
            .step_i    (chain_s[g]),
            .up_i      (dir),
            .digit_o   (dout_s[g*BCD_W +: BCD_W]),
            .wrap_o    (chain_s[g+1])
        );
    end

    // The top digit never wraps while the count is legal and below MODULUS.
    assign unused_top_wrap_s = chain_s[DIGITS];

    // Single-cycle status pulses, registered so outputs have no input path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cout_q     <= 1'b0;
            bout_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cout_q     <= cout_d;
            bout_q     <= bout_d;
            load_err_q <= load_err_d;
        end
    end

    assign dout     = dout_s;
    assign cout     = cout_q;
    assign bout     = bout_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_mod.sv
// Directed self-checking bench for bcd_counter_mod: default mod-60, mod-24
// and a three-digit mod-100 instance share the control inputs.
module tb_bcd_counter_mod;

    logic        clk = 1'b0;
    logic        reset, en, dir, clear, load;
    logic [7:0]  lv_ab;
    logic [11:0] lv_c;
    logic [7:0]  dout_a, dout_b;
    logic [11:0] dout_c;
    logic        cout_a, bout_a, lerr_a;
    logic        cout_b, bout_b, lerr_b;
    logic        cout_c, bout_c, lerr_c;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    bcd_counter_mod u_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv_ab), .dout(dout_a), .cout(cout_a), .bout(bout_a), .load_err(lerr_a));

    bcd_counter_mod #(.DIGITS(2), .MODULUS(24)) u_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv_ab), .dout(dout_b), .cout(cout_b), .bout(bout_b), .load_err(lerr_b));

    bcd_counter_mod #(.DIGITS(3), .MODULUS(100)) u_c (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(lv_c), .dout(dout_c), .cout(cout_c), .bout(bout_c), .load_err(lerr_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; dir = 1'b1; clear = 1'b0; load = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (dout_a !== 8'h00) $display("FAIL reset_dout_a: got %h expected %h", dout_a, 8'h00); else passed++;
        checks++; if (dout_c !== 12'h000) $display("FAIL reset_dout_c: got %h expected %h", dout_c, 12'h000); else passed++;
        checks++; if ({cout_a, bout_a, lerr_a} !== 3'b000) $display("FAIL reset_pulses: got %b expected %b", {cout_a, bout_a, lerr_a}, 3'b000); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        logic [7:0] exp;
        do_reset();
        en = 1'b1; dir = 1'b1;
        for (int i = 1; i < 60; i++) begin
            tick();
            exp[7:4] = 4'(i / 10);
            exp[3:0] = 4'(i % 10);
            checks++; if (dout_a !== exp) $display("FAIL up_dout step %0d: got %h expected %h", i, dout_a, exp); else passed++;
            checks++; if (cout_a !== 1'b0) $display("FAIL up_no_cout step %0d: got %b expected %b", i, cout_a, 1'b0); else passed++;
        end
        tick();
        checks++; if (dout_a !== 8'h00) $display("FAIL up_wrap_dout: got %h expected %h", dout_a, 8'h00); else passed++;
        checks++; if (cout_a !== 1'b1) $display("FAIL up_wrap_cout: got %b expected %b", cout_a, 1'b1); else passed++;
        en = 1'b0;
        tick();
        checks++; if (cout_a !== 1'b0) $display("FAIL cout_single_cycle: got %b expected %b", cout_a, 1'b0); else passed++;
        checks++; if (dout_a !== 8'h00) $display("FAIL hold_dout: got %h expected %h", dout_a, 8'h00); else passed++;
    endtask

    task automatic test_mod24();
        do_reset();
        load = 1'b1; lv_ab = 8'h23;
        tick();
        checks++; if (dout_b !== 8'h23) $display("FAIL m24_load: got %h expected %h", dout_b, 8'h23); else passed++;
        load = 1'b0; en = 1'b1; dir = 1'b1;
        tick();
        checks++; if (dout_b !== 8'h00) $display("FAIL m24_wrap_dout: got %h expected %h", dout_b, 8'h00); else passed++;
        checks++; if (cout_b !== 1'b1) $display("FAIL m24_cout: got %b expected %b", cout_b, 1'b1); else passed++;
        dir = 1'b0;
        tick();
        checks++; if (dout_b !== 8'h23) $display("FAIL m24_down_wrap: got %h expected %h", dout_b, 8'h23); else passed++;
        checks++; if ({cout_b, bout_b} !== 2'b01) $display("FAIL m24_bout: got %b expected %b", {cout_b, bout_b}, 2'b01); else passed++;
        en = 1'b0; load = 1'b1; lv_ab = 8'h24;
        tick();
        checks++; if (lerr_b !== 1'b1) $display("FAIL m24_reject_24: got %b expected %b", lerr_b, 1'b1); else passed++;
        checks++; if ({dout_b, bout_b} !== {8'h23, 1'b0}) $display("FAIL m24_hold_after_reject: got %h expected %h", {dout_b, bout_b}, {8'h23, 1'b0}); else passed++;
        load = 1'b0;
    endtask

    task automatic test_load_err();
        do_reset();
        load = 1'b1; lv_ab = 8'h5A;
        tick();
        checks++; if ({dout_a, lerr_a} !== {8'h00, 1'b1}) $display("FAIL load_5A: got %h expected %h", {dout_a, lerr_a}, {8'h00, 1'b1}); else passed++;
        lv_ab = 8'h60;
        tick();
        checks++; if ({dout_a, lerr_a} !== {8'h00, 1'b1}) $display("FAIL load_60: got %h expected %h", {dout_a, lerr_a}, {8'h00, 1'b1}); else passed++;
        lv_ab = 8'h42;
        tick();
        checks++; if ({dout_a, lerr_a} !== {8'h42, 1'b0}) $display("FAIL load_42: got %h expected %h", {dout_a, lerr_a}, {8'h42, 1'b0}); else passed++;
        lv_ab = 8'h59;
        tick();
        checks++; if ({dout_a, lerr_a} !== {8'h59, 1'b0}) $display("FAIL load_59: got %h expected %h", {dout_a, lerr_a}, {8'h59, 1'b0}); else passed++;
        load = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        load = 1'b1; lv_ab = 8'h59;
        tick();
        checks++; if (dout_a !== 8'h59) $display("FAIL prio_setup: got %h expected %h", dout_a, 8'h59); else passed++;
        clear = 1'b1; load = 1'b1; en = 1'b1; dir = 1'b1; lv_ab = 8'h30;
        tick();
        checks++; if ({dout_a, cout_a} !== {8'h00, 1'b0}) $display("FAIL prio_clear_wins: got %h expected %h", {dout_a, cout_a}, {8'h00, 1'b0}); else passed++;
        clear = 1'b0;
        tick();
        checks++; if ({dout_a, cout_a} !== {8'h30, 1'b0}) $display("FAIL prio_load_over_en: got %h expected %h", {dout_a, cout_a}, {8'h30, 1'b0}); else passed++;
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_down3();
        do_reset();
        en = 1'b1; dir = 1'b0;
        tick();
        checks++; if ({dout_c, bout_c} !== {12'h099, 1'b1}) $display("FAIL d3_wrap: got %h expected %h", {dout_c, bout_c}, {12'h099, 1'b1}); else passed++;
        tick();
        checks++; if ({dout_c, bout_c} !== {12'h098, 1'b0}) $display("FAIL d3_098: got %h expected %h", {dout_c, bout_c}, {12'h098, 1'b0}); else passed++;
        en = 1'b0; load = 1'b1; lv_c = 12'h010;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++; if (dout_c !== 12'h009) $display("FAIL d3_borrow: got %h expected %h", dout_c, 12'h009); else passed++;
        en = 1'b0; load = 1'b1; lv_c = 12'h099;
        tick();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        tick();
        checks++; if ({dout_c, cout_c} !== {12'h000, 1'b1}) $display("FAIL d3_up_wrap: got %h expected %h", {dout_c, cout_c}, {12'h000, 1'b1}); else passed++;
        en = 1'b0; load = 1'b1; lv_c = 12'h100;
        tick();
        checks++; if ({dout_c, lerr_c} !== {12'h000, 1'b1}) $display("FAIL d3_reject_100: got %h expected %h", {dout_c, lerr_c}, {12'h000, 1'b1}); else passed++;
        lv_c = 12'h0A0;
        tick();
        checks++; if ({dout_c, lerr_c} !== {12'h000, 1'b1}) $display("FAIL d3_reject_0A0: got %h expected %h", {dout_c, lerr_c}, {12'h000, 1'b1}); else passed++;
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        load = 1'b1; lv_ab = 8'h37;
        tick();
        checks++; if (dout_a !== 8'h37) $display("FAIL ar_setup: got %h expected %h", dout_a, 8'h37); else passed++;
        load = 1'b0; en = 1'b1; dir = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checks++; if (dout_a !== 8'h00) $display("FAIL ar_immediate: got %h expected %h", dout_a, 8'h00); else passed++;
        checks++; if ({cout_a, bout_a, lerr_a} !== 3'b000) $display("FAIL ar_no_pulse: got %b expected %b", {cout_a, bout_a, lerr_a}, 3'b000); else passed++;
        tick();
        checks++; if (dout_a !== 8'h00) $display("FAIL ar_held: got %h expected %h", dout_a, 8'h00); else passed++;
        reset = 1'b0;
        tick();
        checks++; if (dout_a !== 8'h01) $display("FAIL ar_resume: got %h expected %h", dout_a, 8'h01); else passed++;
        en = 1'b0; load = 1'b1; lv_ab = 8'h59;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++; if (cout_a !== 1'b1) $display("FAIL ar_pulse_setup: got %b expected %b", cout_a, 1'b1); else passed++;
        #3;
        reset = 1'b1;
        #1;
        checks++; if (cout_a !== 1'b0) $display("FAIL ar_kills_cout: got %b expected %b", cout_a, 1'b0); else passed++;
        reset = 1'b0; en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b1; clear = 1'b0; load = 1'b0;
        lv_ab = 8'h00; lv_c = 12'h000;
        #12;
        test_reset();
        test_count_up();
        test_mod24();
        test_load_err();
        test_priority();
        test_down3();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
